// File: rtl/hilo_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// hilo_sequencer_pkg
//
// Shared definitions for the HI/LO multiply/accumulate sequencer: the 3-bit
// operation encoding (also used by ALU control and hazard logic to map
// instructions onto the unit) and the sequencer state encoding.
// -----------------------------------------------------------------------------
package hilo_sequencer_pkg;

    // Operation codes presented on the Op port.
    typedef enum logic [2:0] {
        OpMult  = 3'd0,
        OpMultu = 3'd1,
        OpMadd  = 3'd2,
        OpMsub  = 3'd3,
        OpMthi  = 3'd4,
        OpMtlo  = 3'd5,
        OpMul   = 3'd6,
        OpRsvd  = 3'd7
    } hilo_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIter   = 2'd1,
        StCommit = 2'd2
    } hilo_state_e;

    // Ops whose operands are treated as two's complement.
    function automatic logic op_is_signed(input hilo_op_e op);
        return (op == OpMult) || (op == OpMadd) || (op == OpMsub) || (op == OpMul);
    endfunction

    // Ops that run the full shift-add sequence.
    function automatic logic op_is_multiply(input hilo_op_e op);
        return op_is_signed(op) || (op == OpMultu);
    endfunction

endpackage

// File: rtl/hilo_sequencer_mul_shift_add_step.sv
// -----------------------------------------------------------------------------
// hilo_sequencer_mul_shift_add_step
//
// One radix-2 shift-add multiply iteration, purely combinational.
// If the multiplier LSB is set, the multiplicand is added into the upper half
// of the accumulator; the carry-extended upper half and the accumulator then
// shift right one bit together, as does the multiplier.
//
// Ports:
//   i_acc     2*WIDTH  current product accumulator
//   i_mplier  WIDTH    remaining multiplier bits
//   i_mcand   WIDTH    multiplicand (magnitude)
//   o_acc     2*WIDTH  accumulator after this iteration
//   o_mplier  WIDTH    multiplier after this iteration
// -----------------------------------------------------------------------------
module hilo_sequencer_mul_shift_add_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_mplier,
    input  logic [WIDTH-1:0]   i_mcand,
    output logic [2*WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0]   o_mplier
);

    logic [WIDTH:0] w_sum;
    // The accumulator LSB falls off the end of the shift every iteration.
    logic           w_unused_acc_lsb;

    assign w_unused_acc_lsb = i_acc[0];

    always_comb begin
        w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        if (i_mplier[0]) begin
            w_sum = w_sum + {1'b0, i_mcand};
        end
        // Carry out of the add becomes the new MSB after the shift.
        o_acc    = {w_sum, i_acc[WIDTH-1:1]};
        o_mplier = i_mplier >> 1;
    end

endmodule

// File: rtl/hilo_sequencer.sv
// -----------------------------------------------------------------------------
// hilo_sequencer
//
// Multi-cycle multiply/accumulate unit owning the HI/LO register pair.
// Executes MULT, MULTU, MADD, MSUB, MUL as a WIDTH-iteration radix-2
// shift-add on operand magnitudes followed by a one-cycle sign fix-up and
// commit. MTHI/MTLO write HI/LO directly at the accepting edge.
//
// Ports:
//   i_clk     rising-edge clock
//   i_rst_n   asynchronous active-low reset
//   i_start   request, sampled only in IDLE
//   i_op      operation code (hilo_op_e); reserved code ignored
//   i_a, i_b  rs / rt operands, sampled with i_start
//   i_flush   abort in-flight operation; beats i_start in IDLE
//   o_busy    high while a multiply is in ITER or COMMIT
//   o_done    one-cycle pulse after a committed result
//   o_hi/o_lo architectural HI/LO registers
//   o_result  low product word of the last completed MUL
// -----------------------------------------------------------------------------
module hilo_sequencer
    import hilo_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_flush,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_result
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    // State and datapath registers.
    hilo_state_e        r_state;
    hilo_op_e           r_op;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_neg;
    logic [CntW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_result;
    logic               r_done;

    // Next-state values.
    hilo_state_e        w_state_d;
    hilo_op_e           w_op_d;
    logic [WIDTH-1:0]   w_mcand_d;
    logic [WIDTH-1:0]   w_mplier_d;
    logic [2*WIDTH-1:0] w_prod_d;
    logic               w_neg_d;
    logic [CntW-1:0]    w_cnt_d;
    logic [WIDTH-1:0]   w_hi_d;
    logic [WIDTH-1:0]   w_lo_d;
    logic [WIDTH-1:0]   w_result_d;
    logic               w_done_d;

    // Request decode and operand conditioning.
    hilo_op_e           w_req_op;
    logic               w_req_signed;
    logic               w_accept;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    // Iteration step and commit arithmetic.
    logic [2*WIDTH-1:0] w_step_prod;
    logic [WIDTH-1:0]   w_step_mplier;
    logic [2*WIDTH-1:0] w_signed_prod;
    logic [2*WIDTH-1:0] w_hilo;

    assign w_req_op     = hilo_op_e'(i_op);
    assign w_req_signed = op_is_signed(w_req_op);
    assign w_accept     = (r_state == StIdle) && i_start && !i_flush && (w_req_op != OpRsvd);

    // The most negative value maps onto itself, which reads correctly as an
    // unsigned magnitude.
    assign w_a_mag = (w_req_signed && i_a[WIDTH-1]) ? ('0 - i_a) : i_a;
    assign w_b_mag = (w_req_signed && i_b[WIDTH-1]) ? ('0 - i_b) : i_b;

    assign w_signed_prod = r_neg ? ('0 - r_prod) : r_prod;
    assign w_hilo        = {r_hi, r_lo};

    hilo_sequencer_mul_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc    (r_prod),
        .i_mplier (r_mplier),
        .i_mcand  (r_mcand),
        .o_acc    (w_step_prod),
        .o_mplier (w_step_mplier)
    );

    // Next-state and datapath update.
    always_comb begin
        w_state_d  = r_state;
        w_op_d     = r_op;
        w_mcand_d  = r_mcand;
        w_mplier_d = r_mplier;
        w_prod_d   = r_prod;
        w_neg_d    = r_neg;
        w_cnt_d    = r_cnt;
        w_hi_d     = r_hi;
        w_lo_d     = r_lo;
        w_result_d = r_result;
        w_done_d   = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_req_op == OpMthi) begin
                        w_hi_d   = i_a;
                        w_done_d = 1'b1;
                    end else if (w_req_op == OpMtlo) begin
                        w_lo_d   = i_a;
                        w_done_d = 1'b1;
                    end else if (op_is_multiply(w_req_op)) begin
                        w_op_d     = w_req_op;
                        w_mcand_d  = w_a_mag;
                        w_mplier_d = w_b_mag;
                        w_neg_d    = w_req_signed && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                        w_prod_d   = '0;
                        w_cnt_d    = '0;
                        w_state_d  = StIter;
                    end
                end
            end

            StIter: begin
                if (i_flush) begin
                    w_state_d = StIdle;
                end else begin
                    w_prod_d   = w_step_prod;
                    w_mplier_d = w_step_mplier;
                    w_cnt_d    = r_cnt + 1'b1;
                    if (r_cnt == CntLast) begin
                        w_state_d = StCommit;
                    end
                end
            end

            StCommit: begin
                w_state_d = StIdle;
                // A squash here drops the result entirely.
                if (!i_flush) begin
                    w_done_d = 1'b1;
                    case (r_op)
                        OpMult, OpMultu: {w_hi_d, w_lo_d} = w_signed_prod;
                        OpMadd:          {w_hi_d, w_lo_d} = w_hilo + w_signed_prod;
                        OpMsub:          {w_hi_d, w_lo_d} = w_hilo - w_signed_prod;
                        OpMul:           w_result_d = w_signed_prod[WIDTH-1:0];
                        default:         w_done_d = 1'b0;
                    endcase
                end
            end

            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_op     <= OpMult;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_op     <= w_op_d;
            r_mcand  <= w_mcand_d;
            r_mplier <= w_mplier_d;
            r_prod   <= w_prod_d;
            r_neg    <= w_neg_d;
            r_cnt    <= w_cnt_d;
            r_hi     <= w_hi_d;
            r_lo     <= w_lo_d;
            r_result <= w_result_d;
            r_done   <= w_done_d;
        end
    end

    assign o_busy   = (r_state != StIdle);
    assign o_done   = r_done;
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;
    assign o_result = r_result;

endmodule

// File: tb/tb_hilo_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hilo_sequencer
//
// Directed bench for hilo_sequencer. The stimulus process pushes the expected
// HI/LO/Result and Done cycle for every operation that should commit; a
// monitor pops and compares whenever Done is seen.
// -----------------------------------------------------------------------------
module tb_hilo_sequencer;

    localparam int unsigned W = 32;
    localparam int unsigned MulLat = W + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_MUL   = 3'd6;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] result;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;

    hilo_sequencer #(
        .WIDTH (W)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_op     (op),
        .i_a      (a),
        .i_b      (b),
        .i_flush  (flush),
        .o_busy   (busy),
        .o_done   (done),
        .o_hi     (hi),
        .o_lo     (lo),
        .o_result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void check(input string name, input logic [W-1:0] act,
                                  input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: Done seen at cycle %0d with nothing expected", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("done_cycle", W'(cyc), W'(e.cyc));
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                check("result", result, e.res);
            end
        end
    end

    // One-cycle request; pushes the expected commit if one is due.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit commits, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic [W-1:0] eres);
        int k;
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        k     = cyc + 1;
        if (commits) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.res = eres;
            e.cyc = (o == OP_MTHI || o == OP_MTLO) ? k : k + MulLat;
            q.push_back(e);
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbusy;
        int k;
        exp_t e;

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_busy", W'(busy), 32'h0);
        check("rst_done", W'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // MULT -3 * 5, with Busy width measured.
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0);
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
        end
        check("mult_busy_cycles", W'(nbusy), 32'd33);

        // MULTU and MUL on all-ones operands.
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0);
        repeat (36) @(negedge clk);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 32'h1);
        repeat (36) @(negedge clk);

        // MTLO / MTHI back to back, then MADD and MSUB.
        issue(OP_MTLO, 32'h10, 32'h0, 1'b1, 32'hFFFF_FFFE, 32'h10, 32'h1);
        check("mtlo_busy", W'(busy), 32'h0);
        issue(OP_MTHI, 32'h0, 32'h0, 1'b1, 32'h0, 32'h10, 32'h1);
        check("mthi_busy", W'(busy), 32'h0);
        repeat (3) @(negedge clk);
        issue(OP_MADD, 32'd2, 32'd3, 1'b1, 32'h0, 32'h16, 32'h1);
        repeat (36) @(negedge clk);
        issue(OP_MSUB, 32'd1, 32'h17, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
        repeat (36) @(negedge clk);

        // MULT 7*9 with a stray MTHI while busy, then squashed.
        issue(OP_MULT, 32'd7, 32'd9, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", W'(busy), 32'h0);
        check("flush_hi", hi, 32'hFFFF_FFFF);
        check("flush_lo", lo, 32'hFFFF_FFFF);
        repeat (40) @(negedge clk);
        check("flush_hi_late", hi, 32'hFFFF_FFFF);
        issue(OP_MULTU, 32'd7, 32'd9, 1'b1, 32'h0, 32'd63, 32'h1);
        repeat (36) @(negedge clk);

        // Back-to-back MULTU with Start held high.
        @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd2;
        b     = 32'd3;
        k     = cyc + 1;
        e.hi = 32'h0; e.lo = 32'd6;  e.res = 32'h1; e.cyc = k + MulLat;
        q.push_back(e);
        e.hi = 32'h0; e.lo = 32'd20; e.res = 32'h1; e.cyc = k + MulLat + 1 + MulLat;
        q.push_back(e);
        @(posedge clk);
        #1;
        a = 32'd4;
        b = 32'd5;
        repeat (34) @(posedge clk);
        #1 start = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-ITER, then MTHI after release.
        issue(OP_MULT, 32'd100, 32'd100, 1'b0, 32'h0, 32'h0, 32'h0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        check("midrst_result", result, 32'h0);
        check("midrst_busy", W'(busy), 32'h0);
        check("midrst_done", W'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_MTHI, 32'hA5, 32'h0, 1'b1, 32'hA5, 32'h0, 32'h0);
        repeat (40) @(negedge clk);

        check("queue_drained", W'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
